// File: rtl/mult_stage.sv
// Pipelined RV32M multiplier for the EX stage.
// Shift-add over STAGES cycles; feeds the mult port of the CDB arbiter.
module mult_stage #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 6,
  parameter int STAGES    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 in_valid,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [1:0]           in_func,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [XLEN-1:0]      out_result,
  output logic                 busy
);

  localparam int W2 = 2 * XLEN;
  localparam int C  = W2 / STAGES;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [1:0]           func;
    logic [W2-1:0]        mcand;
    logic [W2-1:0]        mplier;
    logic [W2-1:0]        psum;
  } stage_t;

  // One shift-add step over a C-bit slice of the multiplier.
  function automatic stage_t step(stage_t s);
    logic [W2-1:0] chunk;
    stage_t r;
    r = s;
    chunk = '0;
    chunk[C-1:0] = s.mplier[C-1:0];
    r.psum   = s.psum + s.mcand * chunk;
    r.mcand  = s.mcand << C;
    r.mplier = s.mplier >> C;
    return r;
  endfunction

  stage_t        issue;
  logic          sx1;
  logic          sx2;
  logic [STAGES-1:0] vld;

  always_comb begin
    sx1 = (in_func == F_MULH) || (in_func == F_MULHSU);
    sx2 = (in_func == F_MULH);
    issue        = '0;
    issue.valid  = in_valid;
    issue.tag    = in_tag;
    issue.func   = in_func;
    issue.mcand  = {{XLEN{sx1 & in_rs1[XLEN-1]}}, in_rs1};
    issue.mplier = {{XLEN{sx2 & in_rs2[XLEN-1]}}, in_rs2};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t src;
    stage_t st_d;
    stage_t st_q;

    if (k == 0) begin : g_head
      assign src = issue;
    end else begin : g_body
      assign src = g_st[k-1].st_q;
    end

    always_comb begin
      st_d       = step(src);
      st_d.valid = src.valid & ~squash;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st_q <= '0;
      end else begin
        st_q <= st_d;
      end
    end

    assign vld[k] = st_q.valid;
  end

  stage_t last;
  logic   unused_bits;

  assign last        = g_st[STAGES-1].st_q;
  assign unused_bits = ^{last.mcand, last.mplier};

  // Idle packets are all-zero so the arbiter can OR ports freely.
  always_comb begin
    out_valid  = last.valid;
    out_tag    = '0;
    out_result = '0;
    if (last.valid) begin
      out_tag = last.tag;
      if (last.func == F_MUL) begin
        out_result = last.psum[XLEN-1:0];
      end else begin
        out_result = last.psum[W2-1:XLEN];
      end
    end
  end

  assign busy = |vld;

endmodule
